// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and lane helpers for the write-through data cache
package dcache_pkg;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_WORD = 2'b01,
    WE_HALF = 2'b10,
    WE_BYTE = 2'b11
  } we_e;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } dstate_e;

  function automatic logic [3:0] lane_mask(input we_e we, input logic [1:0] off);
    logic [3:0] m;
    case (we)
      WE_WORD: m = 4'b1111;
      WE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      WE_BYTE: m = 4'b0001 << off;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data is right-justified in wd; replicate it so every enabled lane sees its bytes.
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input we_e we, input logic [1:0] off);
    logic [3:0]  m;
    logic [31:0] src;
    logic [31:0] res;
    m = lane_mask(we, off);
    case (we)
      WE_HALF: src = {2{wd[15:0]}};
      WE_BYTE: src = {4{wd[7:0]}};
      default: src = wd;
    endcase
    for (int l = 0; l < 4; l++) begin
      res[8*l +: 8] = m[l] ? src[8*l +: 8] : old[8*l +: 8];
    end
    return res;
  endfunction

  function automatic logic is_misaligned(input we_e we, input logic [1:0] off);
    return ((we == WE_WORD) && (off != 2'b00)) || ((we == WE_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - tag/data/valid arrays with one read port, one lane-enabled write port
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    clr_all,
  input  logic [INDEX_BITS-1:0]   rd_idx,
  output logic [TAG_BITS-1:0]     rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_idx,
  input  logic [TAG_BITS-1:0]     wr_tag,
  input  logic [DATA_WIDTH/8-1:0] wr_lane_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    clr_a_en,
  input  logic [INDEX_BITS-1:0]   clr_a_idx,
  input  logic                    clr_b_en,
  input  logic [INDEX_BITS-1:0]   clr_b_idx
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // Clears are ordered after the set so an invalidation always wins.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid_q <= '0;
    end else begin
      if (wr_en)    valid_q[wr_idx]    <= 1'b1;
      if (clr_a_en) valid_q[clr_a_idx] <= 1'b0;
      if (clr_b_en) valid_q[clr_b_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int l = 0; l < DATA_WIDTH/8; l++) begin
        if (wr_lane_en[l]) data_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-allocate D-cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [1:0]            WE_i,
  input  logic [31:0]           A_i,
  input  logic [DATA_WIDTH-1:0] WD_i,
  output logic [DATA_WIDTH-1:0] RD_o,
  output logic                  stall_o,
  output logic [1:0]            mem_WE_o,
  output logic [31:0]           mem_A_o,
  output logic [DATA_WIDTH-1:0] mem_WD_o,
  input  logic [DATA_WIDTH-1:0] mem_RD_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  dstate_e state_q, state_d;
  we_e     we;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_valid;
  logic [DATA_WIDTH-1:0] fill_q;

  logic hit, idle_req, is_load, is_store, load_hit, load_miss, misal, store_wr;
  logic                    wr_en;
  logic [DATA_WIDTH/8-1:0] wr_lane_en;
  logic [DATA_WIDTH-1:0]   wr_data;

  assign we  = we_e'(WE_i);
  assign idx = A_i[INDEX_BITS+1:2];
  assign tag = A_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit = line_valid && (line_tag == tag);

  assign idle_req  = (state_q == IDLE) && req_valid_i && !rst;
  assign is_load   = idle_req && (we == WE_NONE);
  assign is_store  = idle_req && (we != WE_NONE);
  assign load_hit  = is_load && hit;
  assign load_miss = is_load && !hit;
  assign misal     = is_store && is_misaligned(we, A_i[1:0]);
  assign store_wr  = is_store && hit && !misal;

  // A refill writes the whole line from memory; a store hit merges only its lanes.
  assign wr_en      = load_miss || store_wr;
  assign wr_lane_en = load_miss ? '1 : lane_mask(we, A_i[1:0]);
  assign wr_data    = load_miss ? mem_RD_i : lane_merge(line_data, WD_i, we, A_i[1:0]);

  dcache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lines (
    .clk        (clk),
    .clr_all    (rst),
    .rd_idx     (idx),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .rd_valid   (line_valid),
    .wr_en      (wr_en),
    .wr_idx     (idx),
    .wr_tag     (tag),
    .wr_lane_en (wr_lane_en),
    .wr_data    (wr_data),
    .clr_a_en   (misal),
    .clr_a_idx  (idx),
    .clr_b_en   (misal),
    .clr_b_idx  (idx + INDEX_BITS'(1))
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else if (load_miss) begin
      fill_q <= mem_RD_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_miss) state_d = REFILL;
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o  = 1'b0;
    RD_o     = '0;
    mem_WE_o = WE_NONE;
    mem_A_o  = A_i;
    mem_WD_o = WD_i;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (load_hit) RD_o = line_data;
          if (load_miss) begin
            stall_o = 1'b1;
            mem_A_o = {A_i[31:2], 2'b00};
          end
          if (is_store) mem_WE_o = WE_i;
        end
        REFILL:  RD_o = fill_q;
        default: RD_o = '0;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (load_hit)  hit_count_o  <= hit_count_o + 32'd1;
      if (load_miss) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - directed vector table plus random traffic against a coherence/tag model
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  WE;
  logic [31:0] A, WD, RD, mem_A, mem_WD, mem_RD;
  logic        stall;
  logic [1:0]  mem_WE;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_wt dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .WE_i        (WE),
    .A_i         (A),
    .WD_i        (WD),
    .RD_o        (RD),
    .stall_o     (stall),
    .mem_WE_o    (mem_WE),
    .mem_A_o     (mem_A),
    .mem_WD_o    (mem_WD),
    .mem_RD_i    (mem_RD)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o (hit_cnt),
    .miss_count_o(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  assign mem_RD = mem[mem_A[17:2]];

  int errors = 0;
  int checks = 0;

  bit          mvalid [64];
  logic [9:0]  mtag   [64];
  int          exp_hits, exp_misses;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_stall;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] we, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (we)
      2'b01: r = wd;
      2'b10: r = off[1] ? {wd[15:0], old[15:0]} : {old[31:16], wd[15:0]};
      2'b11: case (off)
        2'd0: r = {old[31:8], wd[7:0]};
        2'd1: r = {old[31:16], wd[7:0], old[7:0]};
        2'd2: r = {old[31:24], wd[7:0], old[15:0]};
        default: r = {wd[7:0], old[23:0]};
      endcase
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that completes the request.
  task automatic apply(input logic [1:0] we, input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_stall, input logic [31:0] exp_rd, input string nm);
    logic [1:0]  s_we;
    logic [31:0] s_a, s_wd;
    s_we = 2'b00; s_a = '0; s_wd = '0;
    req_valid = 1'b1; WE = we; A = a; WD = wd;
    @(negedge clk);
    if (we == 2'b00) begin
      check({nm, " stall"}, 32'(stall), 32'(exp_stall));
      check({nm, " memwe"}, 32'(mem_WE), 32'd0);
      if (exp_stall) begin
        check({nm, " memA"}, mem_A, {a[31:2], 2'b00});
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, " refill stall"}, 32'(stall), 32'd0);
      end
      check({nm, " rd"}, RD, exp_rd);
    end else begin
      check({nm, " st stall"}, 32'(stall), 32'd0);
      check({nm, " st memwe"}, 32'(mem_WE), 32'(we));
      check({nm, " st memA"}, mem_A, a);
      check({nm, " st memwd"}, mem_WD, wd);
      s_we = mem_WE; s_a = mem_A; s_wd = mem_WD;
    end
    @(posedge clk);
    if (s_we != 2'b00) mem[s_a[17:2]] = mem_merge(mem[s_a[17:2]], s_wd, s_we, s_a[1:0]);
    #1;
  endtask

  // Expectations from the cache rules: hit iff the indexed line holds this tag; loads see memory.
  task automatic model_req(input logic [1:0] we, input logic [31:0] a, input logic [31:0] wd,
                           input string nm);
    logic [5:0]  idx;
    logic [9:0]  tg;
    logic        hit;
    logic [31:0] erd;
    idx = a[7:2];
    tg  = a[17:8];
    hit = mvalid[idx] && (mtag[idx] == tg);
    erd = mem[a[17:2]];
    if (we == 2'b00) begin
      if (hit) exp_hits++;
      else exp_misses++;
    end
    apply(we, a, wd, (we == 2'b00) && !hit, erd, nm);
    if (we == 2'b00 && !hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    if ((we == 2'b01 && a[1:0] != 2'b00) || (we == 2'b10 && a[0])) begin
      mvalid[idx]         = 1'b0;
      mvalid[idx + 6'd1]  = 1'b0;
    end
  endtask

  task automatic idle_cycle(input string nm);
    req_valid = 1'b0;
    @(negedge clk);
    check({nm, " idle stall"}, 32'(stall), 32'd0);
    check({nm, " idle memwe"}, 32'(mem_WE), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  rwe;
    logic [31:0] ra, rwd;
    logic [5:0]  ridx;
    int          r;

    for (int i = 0; i < 65536; i++) mem[i] = (i * 32'h9E3779B1) + 32'h1234;
    mem[16'h4000] = 32'h11223344;
    mem[16'h4040] = 32'h55667788;
    mem[16'h4001] = 32'h99AABBCC;
    mem[16'h4080] = 32'h0BADF00D;
    rst = 1'b1; req_valid = 1'b0; WE = 2'b00; A = '0; WD = '0;

    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b1, 32'h11223344});
    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b0, 32'h11223344});
    vt.push_back('{2'b01, 32'h10000, 32'hDEADBEEF, 1'b0, 32'h0});
    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b0, 32'hDEADBEEF});
    vt.push_back('{2'b11, 32'h10002, 32'h000000AA, 1'b0, 32'h0});
    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b0, 32'hDEAABEEF});
    for (int k = 0; k < 4; k++) begin
      vt.push_back('{2'b00, 32'h10100, 32'h0, 1'b1, 32'h55667788});
      vt.push_back('{2'b00, 32'h10000, 32'h0, 1'b1, 32'hDEAABEEF});
    end
    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b0, 32'hDEAABEEF});
    vt.push_back('{2'b00, 32'h10004, 32'h0,        1'b1, 32'h99AABBCC});
    vt.push_back('{2'b00, 32'h10004, 32'h0,        1'b0, 32'h99AABBCC});
    vt.push_back('{2'b01, 32'h10001, 32'h12345678, 1'b0, 32'h0});
    vt.push_back('{2'b00, 32'h10000, 32'h0,        1'b1, 32'h12345678});
    vt.push_back('{2'b00, 32'h10004, 32'h0,        1'b1, 32'h99AABBCC});

    do_reset();
    @(negedge clk);
    check("reset stall", 32'(stall), 32'd0);
    check("reset memwe", 32'(mem_WE), 32'd0);
    check("reset rd", RD, 32'd0);
`ifdef DCACHE_STATS_EN
    check("reset hits", hit_cnt, 32'd0);
    check("reset misses", miss_cnt, 32'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].we, vt[i].a, vt[i].wd, vt[i].exp_stall, vt[i].exp_rd, $sformatf("vec%0d", i));
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        check("stats hits t1-2", hit_cnt, 32'd2);
        check("stats misses t1-2", miss_cnt, 32'd1);
      end
`endif
    end

    // Reset landing in the REFILL cycle
    req_valid = 1'b1; WE = 2'b00; A = 32'h10200; WD = '0;
    @(negedge clk);
    check("t6 miss stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6 rst stall", 32'(stall), 32'd0);
    check("t6 rst memwe", 32'(mem_WE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle("t6 post");
    apply(2'b00, 32'h10200, 32'h0, 1'b1, 32'h0BADF00D, "t6 reload");

    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle($sformatf("rnd%0d", n));
      end else begin
        r = $urandom_range(0, 7);
        case ($urandom_range(0, 3))
          0: ridx = 6'd0;
          1: ridx = 6'd1;
          2: ridx = 6'd62;
          default: ridx = 6'd63;
        endcase
        ra = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 8) | (32'(ridx) << 2);
        rwd = $urandom;
        if (r < 4) begin
          rwe = 2'b00;
          ra  = ra | 32'($urandom_range(0, 3));
        end else if (r < 6) begin
          rwe = 2'b01;
          if ($urandom_range(0, 4) == 0) ra = ra | 32'($urandom_range(1, 3));
        end else begin
          rwe = (r == 6) ? 2'b10 : 2'b11;
          ra  = ra | 32'($urandom_range(0, 3));
        end
        model_req(rwe, ra, rwd, $sformatf("rnd%0d", n));
      end
    end
    req_valid = 1'b0;
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("rnd hits", hit_cnt, 32'(exp_hits));
    check("rnd misses", miss_cnt, 32'(exp_misses));
`endif
    $display("info: random loads hits=%0d misses=%0d", exp_hits, exp_misses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
